targ_fb_sched: RTL and testbench
================================

Name: targ_fb_sched

Overview:
Feedback scheduler in front of the target predictor's single feedback port. Several branch-resolution ports can each report a resolved (base_pc, targ_pc) pair in the same cycle, but the predictor history table accepts only one update per cycle. This block buffers reports in a FIFO, admits ports round-robin and merges identical same-cycle reports. It drains one entry per cycle into the predictor feedback interface.

Parameters:
fb_ports, 3, number of branch-resolution feedback sources
fifo_depth, 8, FIFO entries (power of two, >= fb_ports)
pc_width, 32, width of base_pc / targ_pc
stall_cnt_width, 16, width of saturating back-pressure counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  global enable; low freezes all state
flush  input  1  discard all buffered feedback
fb_valid  input  fb_ports  per-port feedback valid
fb_base_pc  input  fb_ports x pc_width  per-port branch PC
fb_targ_pc  input  fb_ports x pc_width  per-port resolved target
fb_ready  output  fb_ports  per-port accept (combinational)
out_valid  output  1  feedback valid to predictor
out_base_pc  output  pc_width  head entry branch PC
out_targ_pc  output  pc_width  head entry target
occupancy  output  clog2(fifo_depth)+1  entries held
stall_cnt  output  stall_cnt_width  saturating count of cycles with a refused valid port

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: FIFO empty (head=tail=0, occupancy=0), rr_ptr=0, stall_cnt=0. Outputs are out_valid=0, out_base_pc=0, out_targ_pc=0 and fb_ready=0. Reset overrides flush and en.
- Output: out_valid = en && !flush && occupancy!=0. out_base_pc and out_targ_pc always show the head entry, and 0 when empty. The predictor always accepts, so out_valid implies a pop at that clock edge.
- Latency: feedback accepted in cycle N into an empty FIFO appears on out in cycle N+1. There is no same-cycle bypass.
- Free slots per cycle: free = fifo_depth - occupancy + (pop ? 1 : 0).
- Admission:
  - Scan ports in order rr_ptr, rr_ptr+1, ... (mod fb_ports).
  - A valid port whose (base_pc, targ_pc) equals an earlier-scanned port already granted this cycle is a duplicate. It gets fb_ready=1 and consumes no slot.
  - Otherwise the port is granted if a free slot remains. It is enqueued in scan order and fb_ready=1.
  - Remaining valid ports get fb_ready=0 and must hold their request.
- fb_ready is 0 for every port when en=0 or flush=1.
- Round-robin: if at least one non-duplicate grant occurred, rr_ptr becomes (last non-duplicate granted port + 1) mod fb_ports. Otherwise rr_ptr is unchanged.
- Pointer wrap: head and tail wrap modulo fifo_depth.
- Occupancy update: occupancy_next = occupancy + pushes - pop. It never exceeds fifo_depth and never underflows.
- Full with simultaneous pop: when the FIFO is full and a pop occurs, exactly one new entry may be admitted in the same cycle.
- Flush: head=tail=0 and occupancy=0 next cycle. No pop is issued and no push is accepted. rr_ptr and stall_cnt are retained.
- en=0: no push, no pop, all state held, out_valid=0.
- stall_cnt: increments by 1 on any cycle with en=1, flush=0 and at least one valid port refused. It saturates at all-ones.
- The block does not check entries already in the FIFO for duplicates. Only same-cycle duplicates are merged.

Test Plan:
- Reset then single report: port0 sends (0x100, 0x200) in cycle 1 → fb_ready[0]=1. Cycle 2: out_valid=1, out_base_pc=0x100, out_targ_pc=0x200, occupancy=1. Cycle 3: out_valid=0, occupancy=0.
- Three distinct same-cycle reports into empty FIFO with rr_ptr=0: ports 0, 1, 2 all granted and rr_ptr→0. Outputs then drain in order 0, 1, 2 over three consecutive cycles.
- Duplicate merge: ports 0 and 2 both send (0x40, 0x80) and port 1 sends (0x44, 0x90) → all fb_ready=1, occupancy +2. Output sequence is (0x40, 0x80) then (0x44, 0x90).
- Full FIFO fairness:
  - Fill to 8 with en=1. Then hold all three ports valid with distinct data.
  - Each cycle exactly one port is granted, because the one pop frees one slot.
  - Grants rotate 0, 1, 2, 0…
  - stall_cnt increments every cycle.
- Flush mid-stream: occupancy=5 and flush=1 with port1 valid → fb_ready=0, out_valid=0. Next cycle: occupancy=0, out_valid=0.
- en low and reset override:
  - With occupancy=3, en=0 for 4 cycles → occupancy stays 3, out_valid=0, head data unchanged.
  - Asserting rst together with flush and valid inputs → next cycle everything is at reset values.

Source files
------------

// File: rtl/targ_fb_sched.sv
// Round-robin feedback scheduler: buffers resolved (base_pc, targ_pc) reports and drains one per cycle.
// Entries appear on out_* one cycle after acceptance; ports without a free slot see fb_ready=0 and must hold.
module targ_fb_sched #(
   parameter int fb_ports        = 3,
   parameter int fifo_depth      = 8,
   parameter int pc_width        = 32,
   parameter int stall_cnt_width = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           flush,
   input  logic [fb_ports-1:0]            fb_valid,
   input  logic [fb_ports*pc_width-1:0]   fb_base_pc,
   input  logic [fb_ports*pc_width-1:0]   fb_targ_pc,
   output logic [fb_ports-1:0]            fb_ready,
   output logic                           out_valid,
   output logic [pc_width-1:0]            out_base_pc,
   output logic [pc_width-1:0]            out_targ_pc,
   output logic [$clog2(fifo_depth):0]    occupancy,
   output logic [stall_cnt_width-1:0]     stall_cnt
);

   localparam int PTR_W = $clog2(fifo_depth);
   localparam int RR_W  = (fb_ports > 1) ? $clog2(fb_ports) : 1;

   logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d, wr_ptr;
   logic [PTR_W:0]             occ_q, occ_d, free, n_push;
   logic [RR_W-1:0]            rr_q, rr_d, idx, last_idx;
   logic [stall_cnt_width-1:0] stall_q, stall_d;
   logic [pc_width-1:0]        base_mem_q [fifo_depth];
   logic [pc_width-1:0]        base_mem_d [fifo_depth];
   logic [pc_width-1:0]        targ_mem_q [fifo_depth];
   logic [pc_width-1:0]        targ_mem_d [fifo_depth];
   logic [fb_ports-1:0]        grant_nd, ready;
   logic                       active, pop, dup, any_nd, refused;

   always_comb begin
      active     = en && !flush && !rst;
      pop        = active && (occ_q != '0);
      free       = (PTR_W+1)'(fifo_depth) - occ_q + {{PTR_W{1'b0}}, pop};
      n_push     = '0;
      grant_nd   = '0;
      ready      = '0;
      any_nd     = 1'b0;
      refused    = 1'b0;
      dup        = 1'b0;
      idx        = rr_q;
      last_idx   = rr_q;
      wr_ptr     = tail_q;
      head_d     = head_q;
      tail_d     = tail_q;
      occ_d      = occ_q;
      rr_d       = rr_q;
      stall_d    = stall_q;
      base_mem_d = base_mem_q;
      targ_mem_d = targ_mem_q;

      if (active) begin
         for (int k = 0; k < fb_ports; k++) begin
            idx = (int'(rr_q) + k >= fb_ports) ? RR_W'(int'(rr_q) + k - fb_ports)
                                               : RR_W'(int'(rr_q) + k);
            if (fb_valid[idx]) begin
               // Only ports granted earlier in this scan can be matched as duplicates.
               dup = 1'b0;
               for (int j = 0; j < fb_ports; j++) begin
                  if (grant_nd[j] &&
                      fb_base_pc[j*pc_width +: pc_width] == fb_base_pc[int'(idx)*pc_width +: pc_width] &&
                      fb_targ_pc[j*pc_width +: pc_width] == fb_targ_pc[int'(idx)*pc_width +: pc_width])
                     dup = 1'b1;
               end
               if (dup) begin
                  ready[idx] = 1'b1;
               end else if (n_push < free) begin
                  ready[idx]         = 1'b1;
                  grant_nd[idx]      = 1'b1;
                  wr_ptr             = tail_q + PTR_W'(n_push);
                  base_mem_d[wr_ptr] = fb_base_pc[int'(idx)*pc_width +: pc_width];
                  targ_mem_d[wr_ptr] = fb_targ_pc[int'(idx)*pc_width +: pc_width];
                  n_push             = n_push + (PTR_W+1)'(1);
                  any_nd             = 1'b1;
                  last_idx           = idx;
               end else begin
                  refused = 1'b1;
               end
            end
         end

         tail_d = tail_q + PTR_W'(n_push);
         head_d = head_q + PTR_W'(pop);
         occ_d  = occ_q + n_push - {{PTR_W{1'b0}}, pop};
         if (any_nd)
            rr_d = (int'(last_idx) == fb_ports - 1) ? '0 : last_idx + RR_W'(1);
         if (refused && stall_q != '1)
            stall_d = stall_q + stall_cnt_width'(1);
      end else if (en && flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         rr_q    <= '0;
         stall_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         rr_q    <= rr_d;
         stall_q <= stall_d;
      end
   end

   // Storage needs no reset: the outputs are masked whenever occupancy is zero.
   always_ff @(posedge clk) begin
      base_mem_q <= base_mem_d;
      targ_mem_q <= targ_mem_d;
   end

   assign fb_ready    = ready;
   assign out_valid   = pop;
   assign out_base_pc = (occ_q != '0) ? base_mem_q[head_q] : '0;
   assign out_targ_pc = (occ_q != '0) ? targ_mem_q[head_q] : '0;
   assign occupancy   = occ_q;
   assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_targ_fb_sched.sv
// Bench for targ_fb_sched: directed test-plan steps followed by random traffic against a queue model.
module tb_targ_fb_sched;
   localparam int P  = 3;
   localparam int D  = 8;
   localparam int W  = 32;
   localparam int SW = 16;

   logic           clk = 1'b0;
   logic           rst, en, flush;
   logic [P-1:0]   fb_valid;
   logic [P*W-1:0] fb_base_pc, fb_targ_pc;
   logic [P-1:0]   fb_ready;
   logic           out_valid;
   logic [W-1:0]   out_base_pc, out_targ_pc;
   logic [3:0]     occupancy;
   logic [SW-1:0]  stall_cnt;

   targ_fb_sched #(.fb_ports(P), .fifo_depth(D), .pc_width(W), .stall_cnt_width(SW)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .fb_valid(fb_valid), .fb_base_pc(fb_base_pc), .fb_targ_pc(fb_targ_pc),
      .fb_ready(fb_ready), .out_valid(out_valid), .out_base_pc(out_base_pc),
      .out_targ_pc(out_targ_pc), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] b;
      logic [W-1:0] t;
   } ent_t;

   int         tests = 0;
   int         fails = 0;
   ent_t       mq[$];
   int         m_rr = 0;
   int         m_stall = 0;
   logic [P-1:0] last_ready = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic v, input logic [W-1:0] b, input logic [W-1:0] t);
      fb_valid[p]         = v;
      fb_base_pc[p*W +: W] = b;
      fb_targ_pc[p*W +: W] = t;
   endtask

   // Called at the negedge with inputs already applied; checks, clocks, then advances the model.
   task automatic step();
      ent_t     g[$];
      ent_t     e;
      logic [P-1:0] exp_rdy;
      int       free, last, p;
      bit       act, pop, hit, refused;
      #1;
      act     = en && !flush && !rst;
      pop     = act && (mq.size() > 0);
      free    = D - mq.size() + (pop ? 1 : 0);
      exp_rdy = '0;
      last    = -1;
      refused = 0;
      if (act) begin
         for (int k = 0; k < P; k++) begin
            p = (m_rr + k) % P;
            if (fb_valid[p]) begin
               e   = {fb_base_pc[p*W +: W], fb_targ_pc[p*W +: W]};
               hit = 0;
               foreach (g[i]) if (g[i] == e) hit = 1;
               if (hit) exp_rdy[p] = 1'b1;
               else if (g.size() < free) begin
                  exp_rdy[p] = 1'b1;
                  g.push_back(e);
                  last = p;
               end else refused = 1;
            end
         end
      end
      check("fb_ready", 64'(fb_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(pop));
      check("out_base_pc", 64'(out_base_pc), (mq.size() > 0) ? 64'(mq[0].b) : 64'd0);
      check("out_targ_pc", 64'(out_targ_pc), (mq.size() > 0) ? 64'(mq[0].t) : 64'd0);
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      last_ready = fb_ready;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_rr    = 0;
         m_stall = 0;
      end else if (en) begin
         if (flush) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            foreach (g[i]) mq.push_back(g[i]);
            if (last >= 0) m_rr = (last + 1) % P;
            if (refused && m_stall < (1 << SW) - 1) m_stall++;
         end
      end
      @(negedge clk);
   endtask

   task automatic clear_ports();
      for (int p = 0; p < P; p++) set_port(p, 1'b0, '0, '0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; flush = 1'b0;
      fb_valid = '0; fb_base_pc = '0; fb_targ_pc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      step();
      rst = 1'b0;

      // Single report, one-cycle latency, then empty again.
      set_port(0, 1'b1, 32'h100, 32'h200);
      step();
      clear_ports();
      check("single_out_base", 64'(out_base_pc), 64'h100);
      check("single_out_targ", 64'(out_targ_pc), 64'h200);
      step();
      step();

      // Three distinct reports drain in port order.
      for (int p = 0; p < P; p++) set_port(p, 1'b1, 32'h10 * (p + 1), 32'h11 * (p + 1));
      step();
      clear_ports();
      check("three_occ", 64'(occupancy), 64'd3);
      repeat (4) step();

      // Same-cycle duplicate merge.
      set_port(0, 1'b1, 32'h40, 32'h80);
      set_port(1, 1'b1, 32'h44, 32'h90);
      set_port(2, 1'b1, 32'h40, 32'h80);
      check("dup_ready_pre", 64'(occupancy), 64'd0);
      step();
      clear_ports();
      check("dup_occ", 64'(occupancy), 64'd2);
      repeat (3) step();

      // Saturate the FIFO with all ports busy; grants then rotate one per cycle.
      for (int c = 0; c < 14; c++) begin
         for (int p = 0; p < P; p++)
            if (!fb_valid[p] || last_ready[p])
               set_port(p, 1'b1, 32'h5000 + 32'(c * 16 + p), 32'h9000 + 32'(c * 16 + p));
         step();
      end
      check("full_occ", 64'(occupancy), 64'd8);
      clear_ports();
      repeat (10) step();

      // Flush with five entries held.
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < P; p++) set_port(p, 1'b1, 32'h700 + 32'(c * 4 + p), 32'h800 + 32'(p));
         step();
      end
      clear_ports();
      check("flush_pre_occ", 64'(occupancy), 64'd5);
      flush = 1'b1;
      set_port(1, 1'b1, 32'hABC, 32'hDEF);
      step();
      flush = 1'b0;
      clear_ports();
      check("flush_post_occ", 64'(occupancy), 64'd0);
      step();

      // Enable low freezes everything.
      for (int p = 0; p < P; p++) set_port(p, 1'b1, 32'h900 + 32'(p), 32'hA00 + 32'(p));
      step();
      en = 1'b0;
      repeat (4) step();
      check("en_low_occ", 64'(occupancy), 64'd3);
      en = 1'b1;
      clear_ports();
      step();

      // Reset overrides flush, enable and valid inputs.
      rst = 1'b1; flush = 1'b1;
      for (int p = 0; p < P; p++) set_port(p, 1'b1, 32'hB00 + 32'(p), 32'hC00);
      step();
      rst = 1'b0; flush = 1'b0;
      clear_ports();
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_stall", 64'(stall_cnt), 64'd0);
      step();

      // Random traffic from a small value pool so duplicates occur often.
      for (int c = 0; c < 800; c++) begin
         int v;
         en    = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 29) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < P; p++) begin
            if (!fb_valid[p] || last_ready[p]) begin
               v = $urandom_range(0, 5);
               set_port(p, ($urandom_range(0, 3) != 0), 32'h1000 + 32'(v * 4), 32'h2000 + 32'(v * 8));
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
